// File: rtl/cg_pkg.sv
// Shared definitions for the dot-product row feeder: float width, feeder FSM states
// and the package-count helper.
package cg_pkg;

   localparam int unsigned FLOAT_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      DONE
   } feeder_state_e;

   // Number of NI-lane packages needed to hold noe elements.
   function automatic int unsigned npkg(input int unsigned noe, input int unsigned ni);
      return (noe + ni - 1) / ni;
   endfunction

endpackage

// File: rtl/lane_pad_mask.sv
// Lane-valid mask for package k: all-ones on lanes whose element index is below NOE.
// Lane 0 occupies the most significant 32 bits.
module lane_pad_mask
   import cg_pkg::*;
#(
   parameter int unsigned NOE    = 10,
   parameter int unsigned NI     = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic [ADDR_W-1:0]     k,
   output logic [FLOAT_W*NI-1:0] mask_c
);

   for (genvar i = 0; i < NI; i++) begin : g_lane
      localparam int unsigned LANE = i;
      logic [31:0] elem_idx;
      assign elem_idx = 32'(k) * NI + LANE;
      assign mask_c[FLOAT_W*(NI-i)-1 -: FLOAT_W] = {FLOAT_W{elem_idx < NOE}};
   end

endmodule

// File: rtl/dot_product_row_feeder.sv
// Streams two packed vectors from synchronous-read RAMs as one package pair every two cycles.
// Tail-lane zero padding is built only when DOT_FEEDER_ZERO_PAD_EN is defined.
module dot_product_row_feeder
   import cg_pkg::*;
#(
   parameter int unsigned NOE    = 10,
   parameter int unsigned NI     = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   mem_rd_en,
   input  logic [FLOAT_W*NI-1:0]  mem_a_rdata,
   input  logic [FLOAT_W*NI-1:0]  mem_b_rdata,
   output logic [FLOAT_W*NI-1:0]  first_row_output,
   output logic [FLOAT_W*NI-1:0]  second_row_output,
   output logic                   outsider_read_now,
   output logic [31:0]            no_of_multiples,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned NPKG  = npkg(NOE, NI);
   localparam int unsigned ROW_W = FLOAT_W * NI;
   localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NPKG - 1);

   feeder_state_e     state_q, state_d;
   logic              phase_q, phase_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_en_q, mem_rd_en_d;
   logic [ROW_W-1:0]  first_q, first_d;
   logic [ROW_W-1:0]  second_q, second_d;
   logic              ors_q, ors_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [ROW_W-1:0]  a_pkg_c;
   logic [ROW_W-1:0]  b_pkg_c;

`ifdef DOT_FEEDER_ZERO_PAD_EN
   logic [ROW_W-1:0]  pad_mask_c;

   // k_q still names the package arriving from the RAM when it is registered.
   lane_pad_mask #(
      .NOE    (NOE),
      .NI     (NI),
      .ADDR_W (ADDR_W)
   ) u_lane_pad_mask (
      .k      (k_q),
      .mask_c (pad_mask_c)
   );

   assign a_pkg_c = mem_a_rdata & pad_mask_c;
   assign b_pkg_c = mem_b_rdata & pad_mask_c;
`else
   assign a_pkg_c = mem_a_rdata;
   assign b_pkg_c = mem_b_rdata;
`endif

   // phase_q high marks an even edge: data from the previous read is on the RAM outputs.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      k_d         = k_q;
      mem_addr_d  = mem_addr_q;
      mem_rd_en_d = 1'b0;
      first_d     = first_q;
      second_d    = second_q;
      ors_d       = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = FETCH;
               mem_addr_d  = '0;
               mem_rd_en_d = 1'b1;
               k_d         = '0;
               phase_d     = 1'b0;
               busy_d      = 1'b1;
            end
         end
         FETCH: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               first_d  = a_pkg_c;
               second_d = b_pkg_c;
               ors_d    = (k_q == '0);
               if (k_q < LAST_K) begin
                  k_d         = k_q + ADDR_W'(1);
                  mem_addr_d  = k_q + ADDR_W'(1);
                  mem_rd_en_d = 1'b1;
               end else begin
                  state_d = DRAIN;
                  phase_d = 1'b0;
               end
            end
         end
         DRAIN: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         phase_q     <= 1'b0;
         k_q         <= '0;
         mem_addr_q  <= '0;
         mem_rd_en_q <= 1'b0;
         first_q     <= '0;
         second_q    <= '0;
         ors_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         k_q         <= k_d;
         mem_addr_q  <= mem_addr_d;
         mem_rd_en_q <= mem_rd_en_d;
         first_q     <= first_d;
         second_q    <= second_d;
         ors_q       <= ors_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem_addr          = mem_addr_q;
   assign mem_rd_en         = mem_rd_en_q;
   assign first_row_output  = first_q;
   assign second_row_output = second_q;
   assign outsider_read_now = ors_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign no_of_multiples   = 32'(NPKG);

endmodule

// File: tb/tb_dot_product_row_feeder.sv
// Scoreboard bench for dot_product_row_feeder: three instances (NOE=10, 16, 5; NI=8) fed
// by behavioural RAMs; expected per-cycle outputs are queued at stimulus time.
module tb_dot_product_row_feeder;

   localparam int unsigned NI   = 8;
   localparam int          NINS = 3;

   typedef struct {
      int           at;
      logic         busy;
      logic         done;
      logic         ors;
      logic         rd;
      logic         chk_addr;
      logic [7:0]   addr;
      logic [255:0] a;
      logic [255:0] b;
   } snap_t;

   logic         clk;
   logic         reset;
   logic         start      [NINS];
   logic [7:0]   mem_addr   [NINS];
   logic         mem_rd_en  [NINS];
   logic [255:0] a_rdata    [NINS];
   logic [255:0] b_rdata    [NINS];
   logic [255:0] first_row  [NINS];
   logic [255:0] second_row [NINS];
   logic         ors        [NINS];
   logic [31:0]  nom        [NINS];
   logic         busy       [NINS];
   logic         done       [NINS];

   logic [255:0] ram_a  [NINS][4];
   logic [255:0] ram_b  [NINS][4];
   logic [255:0] last_a [NINS];
   logic [255:0] last_b [NINS];
   logic [255:0] exp_pa [4];
   logic [255:0] exp_pb [4];

   snap_t exp_q [NINS][$];
   snap_t mon_s;
   int    cyc;
   int    tests;
   int    fails;

   dot_product_row_feeder #(.NOE(10), .NI(NI), .ADDR_W(8)) u_dut0 (
      .clk(clk), .reset(reset), .start(start[0]), .mem_addr(mem_addr[0]),
      .mem_rd_en(mem_rd_en[0]), .mem_a_rdata(a_rdata[0]), .mem_b_rdata(b_rdata[0]),
      .first_row_output(first_row[0]), .second_row_output(second_row[0]),
      .outsider_read_now(ors[0]), .no_of_multiples(nom[0]), .busy(busy[0]), .done(done[0]));

   dot_product_row_feeder #(.NOE(16), .NI(NI), .ADDR_W(8)) u_dut1 (
      .clk(clk), .reset(reset), .start(start[1]), .mem_addr(mem_addr[1]),
      .mem_rd_en(mem_rd_en[1]), .mem_a_rdata(a_rdata[1]), .mem_b_rdata(b_rdata[1]),
      .first_row_output(first_row[1]), .second_row_output(second_row[1]),
      .outsider_read_now(ors[1]), .no_of_multiples(nom[1]), .busy(busy[1]), .done(done[1]));

   dot_product_row_feeder #(.NOE(5), .NI(NI), .ADDR_W(8)) u_dut2 (
      .clk(clk), .reset(reset), .start(start[2]), .mem_addr(mem_addr[2]),
      .mem_rd_en(mem_rd_en[2]), .mem_a_rdata(a_rdata[2]), .mem_b_rdata(b_rdata[2]),
      .first_row_output(first_row[2]), .second_row_output(second_row[2]),
      .outsider_read_now(ors[2]), .no_of_multiples(nom[2]), .busy(busy[2]), .done(done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read RAMs: data appears on the edge after the strobe.
   always @(posedge clk) begin
      for (int j = 0; j < NINS; j++) begin
         if (mem_rd_en[j]) begin
            a_rdata[j] <= ram_a[j][mem_addr[j][1:0]];
            b_rdata[j] <= ram_b[j][mem_addr[j][1:0]];
         end
      end
   end

   function automatic int noe_of(input int j);
      case (j)
         0:       return 10;
         1:       return 16;
         default: return 5;
      endcase
   endfunction

   task automatic chk(input string nm, input int j, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, j, cyc, act, exp);
      end
   endtask

   // Scoreboard monitor: compares every queued expectation on its cycle.
   always @(posedge clk) begin
      #1;
      for (int j = 0; j < NINS; j++) begin
         while (exp_q[j].size() > 0 && exp_q[j][0].at <= cyc) begin
            mon_s = exp_q[j].pop_front();
            if (mon_s.at < cyc) begin
               chk("sample_cycle", j, 256'(cyc), 256'(mon_s.at));
            end else begin
               chk("busy", j, 256'(busy[j]), 256'(mon_s.busy));
               chk("done", j, 256'(done[j]), 256'(mon_s.done));
               chk("outsider_read_now", j, 256'(ors[j]), 256'(mon_s.ors));
               chk("mem_rd_en", j, 256'(mem_rd_en[j]), 256'(mon_s.rd));
               if (mon_s.chk_addr) chk("mem_addr", j, 256'(mem_addr[j]), 256'(mon_s.addr));
               chk("first_row_output", j, first_row[j], mon_s.a);
               chk("second_row_output", j, second_row[j], mon_s.b);
            end
         end
      end
   end

   // mode 0: random lanes; mode 1: A=1.0f, B=2.0f, tail lanes DEADBEEF in RAM.
   task automatic fill_ram(input int j, input int mode);
      int noe;
      logic [31:0] va, vb, ea, eb;
      logic [255:0] wa, wb, xa, xb;
      noe = noe_of(j);
      for (int k = 0; k < 4; k++) begin
         wa = '0; wb = '0; xa = '0; xb = '0;
         for (int i = 0; i < int'(NI); i++) begin
            if (mode == 0) begin
               va = $urandom; vb = $urandom;
            end else if (k * int'(NI) + i < noe) begin
               va = 32'h3F800000; vb = 32'h40000000;
            end else begin
               va = 32'hDEADBEEF; vb = 32'hDEADBEEF;
            end
            ea = va; eb = vb;
`ifdef DOT_FEEDER_ZERO_PAD_EN
            if (k * int'(NI) + i >= noe) begin
               ea = 32'h0; eb = 32'h0;
            end
`endif
            wa = (wa << 32) | 256'(va);
            wb = (wb << 32) | 256'(vb);
            xa = (xa << 32) | 256'(ea);
            xb = (xb << 32) | 256'(eb);
         end
         ram_a[j][k] = wa;
         ram_b[j][k] = wb;
         exp_pa[k]   = xa;
         exp_pb[k]   = xb;
      end
   endtask

   // Expected outputs during the cycle after edge E(t) of a run that started at e0.
   task automatic push_run(input int j, input int e0, input int t, input int npk);
      snap_t s;
      int p;
      s.at       = e0 + t;
      s.busy     = (t < 2 * npk + 2);
      s.done     = (t == 2 * npk + 2);
      s.ors      = (t == 2);
      s.rd       = (t % 2 == 0) && (t / 2 < npk);
      s.chk_addr = s.rd;
      s.addr     = 8'(t / 2);
      if (t < 2) begin
         s.a = last_a[j];
         s.b = last_b[j];
      end else begin
         p = (t - 2) / 2;
         if (p > npk - 1) p = npk - 1;
         s.a = exp_pa[p];
         s.b = exp_pb[p];
      end
      exp_q[j].push_back(s);
   endtask

   task automatic push_zero(input int j, input int at);
      snap_t s;
      s.at = at; s.busy = 1'b0; s.done = 1'b0; s.ors = 1'b0; s.rd = 1'b0;
      s.chk_addr = 1'b1; s.addr = 8'h0; s.a = '0; s.b = '0;
      exp_q[j].push_back(s);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         for (int i = 0; i < NINS; i++) start[i] = 1'b0;
      end
   endtask

   task automatic run_txn(input int j, input int mode, input bit poke_busy, input bit poke_done);
      int npk, e0, tlast;
      npk = (noe_of(j) + 7) / 8;
      fill_ram(j, mode);
      @(negedge clk);
      for (int i = 0; i < NINS; i++) start[i] = 1'b0;
      start[j] = 1'b1;
      e0 = cyc + 1;
      tlast = 2 * npk + 2 + (poke_done ? 1 : 0);
      for (int t = 0; t <= tlast; t++) push_run(j, e0, t, npk);
      last_a[j] = exp_pa[npk - 1];
      last_b[j] = exp_pb[npk - 1];
      for (int t = 1; t <= 2 * npk + 3; t++) begin
         @(negedge clk);
         start[j] = (poke_busy && (t == 1 || t == 3)) || (poke_done && t == 2 * npk + 3);
      end
   endtask

   task automatic reset_mid(input int j);
      int npk, e0;
      npk = (noe_of(j) + 7) / 8;
      fill_ram(j, 0);
      @(negedge clk);
      for (int i = 0; i < NINS; i++) start[i] = 1'b0;
      start[j] = 1'b1;
      e0 = cyc + 1;
      for (int t = 0; t <= 2; t++) push_run(j, e0, t, npk);
      for (int i = 0; i < NINS; i++) begin
         push_zero(i, e0 + 3);
         last_a[i] = '0;
         last_b[i] = '0;
      end
      for (int t = 1; t <= 3; t++) begin
         @(negedge clk);
         start[j] = 1'b0;
         if (t == 3) reset = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      for (int i = 0; i < NINS; i++) begin
         start[i]  = 1'b0;
         last_a[i] = '0;
         last_b[i] = '0;
         for (int k = 0; k < 4; k++) begin
            ram_a[i][k] = '0;
            ram_b[i][k] = '0;
         end
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < NINS; i++) push_zero(i, cyc + 1);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NINS; i++)
         chk("no_of_multiples", i, 256'(nom[i]), 256'((noe_of(i) + 7) / 8));

      run_txn(0, 1, 1'b0, 1'b0);
      idle(2);
      run_txn(1, 1, 1'b0, 1'b0);
      run_txn(2, 1, 1'b0, 1'b1);
      run_txn(2, 0, 1'b0, 1'b0);
      run_txn(0, 0, 1'b1, 1'b0);
      run_txn(1, 0, 1'b1, 1'b1);
      run_txn(1, 0, 1'b0, 1'b0);
      reset_mid(0);
      run_txn(0, 0, 1'b0, 1'b0);
      reset_mid(2);
      run_txn(2, 0, 1'b1, 1'b0);
      for (int n = 0; n < 8; n++) begin
         run_txn(int'($urandom_range(0, NINS - 1)), 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
      idle(6);

      for (int i = 0; i < NINS; i++)
         chk("queue_drained", i, 256'(exp_q[i].size()), 256'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
